// File: rtl/code_entry_ctrl.sv
// rtl/code_entry_ctrl.sv - keypad code entry controller with retry limit and timed lockout
// Four-digit 2-bit code entry; all outputs are registered next-state values.
module code_entry_ctrl #(
  parameter int         MAX_TRIES   = 3,
  parameter int         LOCK_CYCLES = 1000,
  parameter logic [7:0] RESET_CODE  = 8'h1B
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] btn_pulse,
  input  logic       enter_pulse,
  input  logic       clr_pulse,
  input  logic       load_en,
  input  logic [7:0] load_code,
  output logic [7:0] entered_code,
  output logic [2:0] digit_cnt,
  output logic       unlock,
  output logic       fail,
  output logic       lockout,
  output logic [1:0] attempts_left,
  output logic       arb_drop
);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCKED, LOCKOUT} state_t;

  state_t      state, state_n;
  logic [7:0]  secret, secret_n;
  logic [7:0]  code_n;
  logic [2:0]  cnt_n;
  logic        unlock_n, fail_n, lockout_n, drop_n;
  logic [1:0]  att_n;
  logic [15:0] lock_cnt, lock_cnt_n;
  logic [1:0]  digit;
  logic        btn_any, btn_multi;

  // Lowest-index button wins arbitration.
  always_comb begin
    digit = 2'd3;
    if (btn_pulse[0])      digit = 2'd0;
    else if (btn_pulse[1]) digit = 2'd1;
    else if (btn_pulse[2]) digit = 2'd2;
  end

  assign btn_any   = |btn_pulse;
  assign btn_multi = (btn_pulse & (btn_pulse - 4'd1)) != 4'd0;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state         <= IDLE;
      secret        <= RESET_CODE;
      entered_code  <= 8'd0;
      digit_cnt     <= 3'd0;
      unlock        <= 1'b0;
      fail          <= 1'b0;
      lockout       <= 1'b0;
      attempts_left <= 2'(MAX_TRIES);
      arb_drop      <= 1'b0;
      lock_cnt      <= 16'd0;
    end else begin
      state         <= state_n;
      secret        <= secret_n;
      entered_code  <= code_n;
      digit_cnt     <= cnt_n;
      unlock        <= unlock_n;
      fail          <= fail_n;
      lockout       <= lockout_n;
      attempts_left <= att_n;
      arb_drop      <= drop_n;
      lock_cnt      <= lock_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    secret_n   = secret;
    code_n     = entered_code;
    cnt_n      = digit_cnt;
    unlock_n   = unlock;
    fail_n     = 1'b0;
    lockout_n  = lockout;
    att_n      = attempts_left;
    drop_n     = btn_any;
    lock_cnt_n = lock_cnt;

    case (state)
      IDLE, ENTRY: begin
        // Secret load is independent of whatever else happens this cycle.
        if (state == IDLE && load_en) secret_n = load_code;
        if (clr_pulse) begin
          code_n  = 8'd0;
          cnt_n   = 3'd0;
          state_n = IDLE;
        end else if (enter_pulse) begin
          state_n = CHECK;
        end else if (btn_any && digit_cnt < 3'd4) begin
          code_n  = {entered_code[5:0], digit};
          cnt_n   = digit_cnt + 3'd1;
          state_n = ENTRY;
          drop_n  = btn_multi;
        end
      end

      CHECK: begin
        if (digit_cnt == 3'd4 && entered_code == secret) begin
          state_n  = UNLOCKED;
          unlock_n = 1'b1;
          att_n    = 2'(MAX_TRIES);
        end else begin
          fail_n = 1'b1;
          att_n  = attempts_left - 2'd1;
          code_n = 8'd0;
          cnt_n  = 3'd0;
          if (attempts_left <= 2'd1) begin
            state_n    = LOCKOUT;
            lockout_n  = 1'b1;
            lock_cnt_n = 16'(LOCK_CYCLES - 1);
          end else begin
            state_n = IDLE;
          end
        end
      end

      UNLOCKED: begin
        if (clr_pulse) begin
          unlock_n = 1'b0;
          code_n   = 8'd0;
          cnt_n    = 3'd0;
          state_n  = IDLE;
        end
      end

      LOCKOUT: begin
        if (lock_cnt == 16'd0) begin
          state_n   = IDLE;
          lockout_n = 1'b0;
          att_n     = 2'(MAX_TRIES);
        end else begin
          lock_cnt_n = lock_cnt - 16'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/code_entry_ctrl.md
CODE_ENTRY_CTRL -- requirements
Module: code_entry_ctrl

Interface
REQ-001 Parameter MAX_TRIES, default 3, failed attempts allowed before lockout; legal range 1..3.
REQ-002 Parameter LOCK_CYCLES, default 1000, lockout duration in Clk cycles; legal range 1..65535.
REQ-003 Parameter RESET_CODE, default 8'h1B, secret code after reset, four 2-bit digits, first digit in [7:6].
REQ-004 Clk  input  1  clock; all state updates on rising edge.
REQ-005 Rst  input  1  reset, synchronous, active-low.
REQ-006 btn_pulse  input  4  one-cycle pulses from the button shapers; bit i means digit i.
REQ-007 enter_pulse  input  1  one-cycle pulse requesting a code check.
REQ-008 clr_pulse  input  1  one-cycle pulse that clears the entry or relocks.
REQ-009 load_en  input  1  level; writes load_code into the secret register.
REQ-010 load_code  input  8  new secret code.
REQ-011 entered_code  output  8  digits entered so far, most recent digit in [1:0].
REQ-012 digit_cnt  output  3  number of digits entered, 0..4.
REQ-013 unlock  output  1  level; high while in UNLOCKED.
REQ-014 fail  output  1  one-cycle pulse on each failed check.
REQ-015 lockout  output  1  level; high while in LOCKOUT.
REQ-016 attempts_left  output  2  remaining attempts.
REQ-017 arb_drop  output  1  one-cycle pulse when a digit press is discarded by arbitration.

Function
REQ-018 The FSM SHALL have states IDLE, ENTRY, CHECK, UNLOCKED and LOCKOUT; all outputs SHALL be registered.
REQ-019 Per-cycle input priority SHALL be clr_pulse > enter_pulse > btn_pulse; among btn_pulse bits, the lowest index SHALL win.
REQ-020 arb_drop SHALL pulse on the next cycle whenever a btn_pulse bit is present but not accepted: a losing bit, a lost-priority press, a press with digit_cnt==4, or a press in CHECK or LOCKOUT.
REQ-021 An accepted digit d SHALL update the outputs one cycle later: entered_code becomes {entered_code[5:0], d} and digit_cnt increments.
REQ-022 An accepted digit in IDLE SHALL move the FSM to ENTRY; digit_cnt SHALL saturate at 4.
REQ-023 enter_pulse in IDLE or ENTRY SHALL move the FSM to CHECK for exactly one cycle.
REQ-024 In CHECK, the entry SHALL match only if digit_cnt==4 and entered_code equals the secret; fewer than 4 digits SHALL count as a mismatch.
REQ-025 On a match, the FSM SHALL go to UNLOCKED, set attempts_left to MAX_TRIES and raise unlock.
REQ-026 On a mismatch, the block SHALL pulse fail, decrement attempts_left and clear entered_code and digit_cnt.
REQ-027 After a mismatch, the FSM SHALL go to LOCKOUT if attempts_left reaches 0, otherwise to IDLE.
REQ-028 unlock and fail SHALL be observable two edges after the edge that samples enter_pulse.
REQ-029 clr_pulse in IDLE or ENTRY SHALL clear entered_code and digit_cnt and go to IDLE without consuming an attempt.
REQ-030 clr_pulse in UNLOCKED SHALL additionally deassert unlock.
REQ-031 clr_pulse SHALL be ignored in CHECK and LOCKOUT.
REQ-032 UNLOCKED SHALL ignore btn_pulse and enter_pulse.
REQ-033 LOCKOUT SHALL load a 16-bit down-counter with LOCK_CYCLES-1 on entry and ignore all pulses.
REQ-034 When the LOCKOUT counter reaches 0, the FSM SHALL return to IDLE with attempts_left=MAX_TRIES and lockout deasserted; lockout SHALL stay high for exactly LOCK_CYCLES cycles.
REQ-035 load_en SHALL write the secret only in IDLE; in other states it SHALL be ignored.
REQ-036 A load_en in the same cycle as an accepted digit SHALL still write the secret.

Reset
REQ-037 While Rst==0 at a rising edge, the block SHALL enter IDLE and load the secret with RESET_CODE.
REQ-038 Reset SHALL set entered_code=0, digit_cnt=0, unlock=0, fail=0, lockout=0, arb_drop=0 and attempts_left=MAX_TRIES.
REQ-039 Reset SHALL clear the lockout counter.
REQ-040 Reset SHALL take effect from any state, including mid-entry and mid-lockout.

Verification
REQ-041 Bench scenario, correct code: after reset, press digits 0,1,2,3 and then enter -> entered_code=8'h1B, digit_cnt=4, unlock=1 two edges after enter, attempts_left=3.
REQ-042 Bench scenario, arbitration: btn_pulse=4'b0110 in one cycle -> digit 1 accepted, arb_drop=1 for one cycle, digit_cnt +1.
REQ-043 Bench scenario, three failures: enter 0,0,0,0 three times -> fail pulses with attempts_left 2,1,0, then lockout high for exactly 1000 cycles with digits ignored and arb_drop pulsing, then IDLE with attempts_left=3.
REQ-044 Bench scenario, same-cycle priority: clr_pulse with enter_pulse after 3 digits -> IDLE, digit_cnt=0, no fail, attempts_left unchanged.
REQ-045 Bench scenario, load then check: load_code=8'hE4 in IDLE, then press 3,2,1,0 and enter -> unlock=1; then clr_pulse -> unlock=0, state IDLE.
REQ-046 Bench scenario, reset mid-operation: Rst=0 for one edge during LOCKOUT -> lockout=0, attempts_left=3, secret restored to 8'h1B.
